// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared constants and helpers for the SDRAM port arbiter.
//   - FSM state encoding (ST_IDLE, ST_ISSUE, ST_WR_BURST, ST_RD_BURST)
//   - client indices: CLI_VGA=0 (line fetch), CLI_HOST=1 (pixel writer),
//     CLI_FILL=2 (fill/blit engine)
//   - bus widths ADDR_W and DATA_W
//   - next_cli(): round-robin successor, cli_onehot(): index to 3-bit mask
package sdram_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WR_BURST = 2'd2;
    localparam logic [1:0] ST_RD_BURST = 2'd3;

    localparam logic [1:0] CLI_VGA  = 2'd0;
    localparam logic [1:0] CLI_HOST = 2'd1;
    localparam logic [1:0] CLI_FILL = 2'd2;

    // Successor of a client index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] next_cli(input logic [1:0] cli);
        case (cli)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // One-hot mask for a client index; out-of-range indices map to no client.
    function automatic logic [2:0] cli_onehot(input logic [1:0] cli);
        case (cli)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational winner selection for three clients.
// Priority: starving requester (lowest index) > urgent client 0 >
// round-robin starting after last_grant.
//   req        in  3  per-client request
//   urgent     in  1  client 0 urgency
//   last_grant in  2  index of the most recent grant
//   starve     in  3  per-client starvation flag
//   valid      out 1  at least one client requesting
//   idx        out 2  winning client index (CLI_VGA when nobody requests)
module rr_pick3
    import sdram_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic       urgent,
    input  logic [1:0] last_grant,
    input  logic [2:0] starve,
    output logic       valid,
    output logic [1:0] idx
);

    logic [2:0] starve_req_s;
    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;

    // Priority-ordered winner selection.
    always_comb begin
        starve_req_s = starve & req;
        first_s      = next_cli(last_grant);
        second_s     = next_cli(first_s);
        third_s      = next_cli(second_s);
        valid        = |req;
        idx          = CLI_VGA;
        if (starve_req_s[0]) begin
            idx = CLI_VGA;
        end else if (starve_req_s[1]) begin
            idx = CLI_HOST;
        end else if (starve_req_s[2]) begin
            idx = CLI_FILL;
        end else if (req[0] && urgent) begin
            idx = CLI_VGA;
        end else if (req[first_s]) begin
            idx = first_s;
        end else if (req[second_s]) begin
            idx = second_s;
        end else if (req[third_s]) begin
            idx = third_s;
        end else begin
            idx = CLI_VGA;
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: grants the single SDRAM controller port to one of three
// clients (0 VGA fetch, 1 host writer, 2 fill/blit) one burst at a time,
// muxes address/data and routes ack / write-strobe / read-valid pulses back
// to the owning client.
// Optional build macro SDRAM_ARB_STARVE_EN adds per-client wait counters that
// force a grant once a client has waited MAX_WAIT cycles.
// Ports:
//   mem_clk, reset          clock, synchronous active-high reset
//   cli_req/we/addr/wdata   packed per-client request, direction, address, data
//   cli0_urgent             client 0 FIFO low
//   cli_ack                 one-cycle accept pulse to granted client
//   cli_wr_next/rd_valid    routed controller strobes
//   mem_rd_req/wr_req       registered request to controller
//   mem_addr, mem_wr_data   granted address (registered) and write data (muxed)
//   mem_ack, mem_wr_data_next, mem_rd_data_valid  controller handshake
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int NUM_CLI   = 3,
    parameter int MAX_WAIT  = 255
) (
    input  logic                      mem_clk,
    input  logic                      reset,
    input  logic [NUM_CLI-1:0]        cli_req,
    input  logic [NUM_CLI-1:0]        cli_we,
    input  logic [NUM_CLI*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLI*DATA_W-1:0] cli_wdata,
    input  logic                      cli0_urgent,
    output logic [NUM_CLI-1:0]        cli_ack,
    output logic [NUM_CLI-1:0]        cli_wr_next,
    output logic [NUM_CLI-1:0]        cli_rd_valid,
    output logic                      mem_rd_req,
    output logic                      mem_wr_req,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wr_data,
    input  logic                      mem_ack,
    input  logic                      mem_wr_data_next,
    input  logic                      mem_rd_data_valid
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    logic [1:0]        state_r;
    logic [1:0]        grant_r;
    logic [1:0]        last_grant_r;
    logic              we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_rd_req_r;
    logic              mem_wr_req_r;
    logic [CNT_W-1:0]  burst_cnt_r;

    logic              pick_valid_s;
    logic [1:0]        pick_idx_s;
    logic [2:0]        starve_s;
    logic [2:0]        grant_oh_s;
    logic              strobe_s;

    rr_pick3 u_pick (
        .req        (cli_req),
        .urgent     (cli0_urgent),
        .last_grant (last_grant_r),
        .starve     (starve_s),
        .valid      (pick_valid_s),
        .idx        (pick_idx_s)
    );

`ifdef SDRAM_ARB_STARVE_EN
    logic [7:0] wait_cnt_r [3];
    logic [2:0] owner_s;

    // Current burst owner does not accumulate waiting time.
    always_comb begin
        if (state_r != ST_IDLE) begin
            owner_s = grant_oh_s;
        end else begin
            owner_s = 3'b000;
        end
        for (int i = 0; i < 3; i++) begin
            starve_s[i] = (wait_cnt_r[i] == 8'(MAX_WAIT));
        end
    end

    // Saturating per-client wait counters, cleared when the client wins.
    always_ff @(posedge mem_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                wait_cnt_r[i] <= 8'd0;
            end else if ((state_r == ST_IDLE) && pick_valid_s && (pick_idx_s == 2'(i))) begin
                wait_cnt_r[i] <= 8'd0;
            end else if (cli_req[i] && !owner_s[i] && (wait_cnt_r[i] < 8'(MAX_WAIT))) begin
                wait_cnt_r[i] <= wait_cnt_r[i] + 8'd1;
            end else begin
                wait_cnt_r[i] <= wait_cnt_r[i];
            end
        end
    end
`else
    // Without starvation protection no client is ever forced.
    always_comb begin
        starve_s = 3'b000;
    end
`endif

    // Select which controller strobe advances the current burst.
    always_comb begin
        grant_oh_s = cli_onehot(grant_r);
        case (state_r)
            ST_WR_BURST: strobe_s = mem_wr_data_next;
            ST_RD_BURST: strobe_s = mem_rd_data_valid;
            default:     strobe_s = 1'b0;
        endcase
    end

    // Arbitration / sequencing FSM with registered controller request.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= 2'd0;
            last_grant_r <= 2'd2;
            we_r         <= 1'b0;
            mem_addr_r   <= '0;
            mem_rd_req_r <= 1'b0;
            mem_wr_req_r <= 1'b0;
            burst_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_r      <= ST_ISSUE;
                        grant_r      <= pick_idx_s;
                        last_grant_r <= pick_idx_s;
                        we_r         <= cli_we[pick_idx_s];
                        mem_addr_r   <= cli_addr[pick_idx_s*ADDR_W +: ADDR_W];
                        mem_wr_req_r <= cli_we[pick_idx_s];
                        mem_rd_req_r <= ~cli_we[pick_idx_s];
                        burst_cnt_r  <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        mem_wr_req_r <= 1'b0;
                        mem_rd_req_r <= 1'b0;
                        state_r      <= we_r ? ST_WR_BURST : ST_RD_BURST;
                    end
                end
                ST_WR_BURST, ST_RD_BURST: begin
                    if (strobe_s) begin
                        burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                        if (burst_cnt_r == CNT_LAST) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Route handshakes to the owner only; write data is muxed only while a
    // burst is in flight so the idle port shows all zeros.
    always_comb begin
        mem_rd_req = mem_rd_req_r;
        mem_wr_req = mem_wr_req_r;
        mem_addr   = mem_addr_r;
        if ((state_r == ST_ISSUE) && mem_ack) begin
            cli_ack = grant_oh_s;
        end else begin
            cli_ack = 3'b000;
        end
        if ((state_r == ST_WR_BURST) && mem_wr_data_next) begin
            cli_wr_next = grant_oh_s;
        end else begin
            cli_wr_next = 3'b000;
        end
        if ((state_r == ST_RD_BURST) && mem_rd_data_valid) begin
            cli_rd_valid = grant_oh_s;
        end else begin
            cli_rd_valid = 3'b000;
        end
        if (state_r == ST_IDLE) begin
            mem_wr_data = '0;
        end else begin
            mem_wr_data = cli_wdata[grant_r*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb: directed scenarios plus randomized
// bursts, checked against a rule-level reference of the arbitration policy.
module tb_sdram_port_arb;

    logic        mem_clk = 1'b0;
    logic        reset;
    logic [2:0]  cli_req;
    logic [2:0]  cli_we;
    logic [74:0] cli_addr;
    logic [95:0] cli_wdata;
    logic        cli0_urgent;
    logic [2:0]  cli_ack;
    logic [2:0]  cli_wr_next;
    logic [2:0]  cli_rd_valid;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [24:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_ack;
    logic        mem_wr_data_next;
    logic        mem_rd_data_valid;

    int checks = 0;
    int errors = 0;
    int model_last = 2;

    always #5 mem_clk = ~mem_clk;

    sdram_port_arb #(.BURST_LEN(8), .NUM_CLI(3), .MAX_WAIT(20)) dut (
        .mem_clk           (mem_clk),
        .reset             (reset),
        .cli_req           (cli_req),
        .cli_we            (cli_we),
        .cli_addr          (cli_addr),
        .cli_wdata         (cli_wdata),
        .cli0_urgent       (cli0_urgent),
        .cli_ack           (cli_ack),
        .cli_wr_next       (cli_wr_next),
        .cli_rd_valid      (cli_rd_valid),
        .mem_rd_req        (mem_rd_req),
        .mem_wr_req        (mem_wr_req),
        .mem_addr          (mem_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_ack           (mem_ack),
        .mem_wr_data_next  (mem_wr_data_next),
        .mem_rd_data_valid (mem_rd_data_valid)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    // Policy: urgent client 0 first, else first requester after last grant.
    function automatic int ref_winner(input logic [2:0] req, input logic urg, input int last);
        if (req[0] && urg) return 0;
        for (int k = 1; k <= 3; k++) begin
            if (req[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic new_req(input int c);
        cli_req[c]               = 1'b1;
        cli_we[c]                = 1'($urandom_range(0, 1));
        cli_addr[c*25 +: 25]     = 25'($urandom);
        cli_wdata[c*32 +: 32]    = $urandom;
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, 64'({cli_ack, cli_wr_next, cli_rd_valid, mem_rd_req, mem_wr_req}), 64'd0);
        check_eq(tag, 64'({mem_addr, mem_wr_data}), 64'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cli_req = 3'b000;
        mem_ack = 1'b0;
        mem_wr_data_next = 1'b0;
        mem_rd_data_valid = 1'b0;
        cli0_urgent = 1'b0;
        repeat (2) tick();
        check_quiet("reset_state");
        reset = 1'b0;
        model_last = 2;
    endtask

    // One full transaction: wait for issue, ack, stop_at strobes, then (for a
    // complete burst) refill requests and send one stray strobe pair.
    task automatic run_burst(input logic [2:0] refill, input bit rnd, input int stop_at,
                             output int win, output int lat);
        int n = 0;
        int exp;
        int obs;
        bit wr;
        win = -1;
        lat = -1;
        while (!(mem_rd_req || mem_wr_req) && n < 20) begin
            tick();
            n++;
        end
        if (!(mem_rd_req || mem_wr_req)) begin
            check_eq("issue_timeout", 64'd1, 64'd0);
            return;
        end
        lat = n;
        exp = ref_winner(cli_req, cli0_urgent, model_last);
        repeat ($urandom_range(0, 2)) begin
            check_eq("req_hold", 64'(mem_rd_req | mem_wr_req), 64'd1);
            tick();
        end
        mem_ack = 1'b1;
        #1;
        obs = -1;
        for (int c = 0; c < 3; c++) if (cli_ack[c]) obs = c;
`ifdef SDRAM_ARB_STARVE_EN
        if (obs >= 0 && cli_req[obs]) exp = obs;
`endif
        if (exp < 0) exp = 0;
        check_eq("grant_ack", 64'(cli_ack), 64'(3'b001 << exp));
        wr = cli_we[exp];
        check_eq("req_type", 64'({mem_rd_req, mem_wr_req}), 64'({!wr, wr}));
        check_eq("addr", 64'(mem_addr), 64'(cli_addr[exp*25 +: 25]));
        check_eq("issue_wdata", 64'(mem_wr_data), 64'(cli_wdata[exp*32 +: 32]));
        tick();
        mem_ack = 1'b0;
        #1;
        check_eq("ack_drop", 64'({cli_ack, mem_rd_req, mem_wr_req}), 64'd0);
        model_last = exp;
        win = exp;
        cli_req[exp] = 1'b0;
        for (int i = 0; i < stop_at; i++) begin
            repeat ($urandom_range(0, 2)) begin
                if (wr) mem_rd_data_valid = 1'($urandom_range(0, 1));
                else    mem_wr_data_next  = 1'($urandom_range(0, 1));
                #1;
                check_eq("gap_quiet", 64'({cli_wr_next, cli_rd_valid}), 64'd0);
                tick();
                mem_rd_data_valid = 1'b0;
                mem_wr_data_next  = 1'b0;
            end
            if (wr) mem_wr_data_next = 1'b1;
            else    mem_rd_data_valid = 1'b1;
            #1;
            check_eq("route", 64'({cli_wr_next, cli_rd_valid}),
                     wr ? 64'({3'b001 << exp, 3'b000}) : 64'({3'b000, 3'b001 << exp}));
            if (wr) check_eq("burst_wdata", 64'(mem_wr_data), 64'(cli_wdata[exp*32 +: 32]));
            if (i + 1 == stop_at && stop_at < 8) return;
            tick();
            mem_wr_data_next  = 1'b0;
            mem_rd_data_valid = 1'b0;
            if (wr) cli_wdata[exp*32 +: 32] = $urandom;
        end
        for (int c = 0; c < 3; c++) if (refill[c] && !cli_req[c]) new_req(c);
        if (rnd) begin
            for (int c = 0; c < 3; c++) if (!cli_req[c] && $urandom_range(0, 1) == 1) new_req(c);
            if (cli_req == 3'b000) new_req($urandom_range(0, 2));
            cli0_urgent = 1'($urandom_range(0, 1));
        end
        mem_wr_data_next  = 1'b1;
        mem_rd_data_valid = 1'b1;
        #1;
        check_eq("stray_strobe", 64'({cli_wr_next, cli_rd_valid}), 64'd0);
        tick();
        mem_wr_data_next  = 1'b0;
        mem_rd_data_valid = 1'b0;
    endtask

    // Controller request lines must be mutually exclusive at all times.
    always @(negedge mem_clk) begin
        check_eq("rd_wr_excl", 64'(mem_rd_req & mem_wr_req), 64'd0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int win;
        int lat;
        int alt_exp [4];
        bit seen1;
        alt_exp = '{1, 2, 1, 2};
        cli_we = 3'b000;
        cli_addr = '0;
        cli_wdata = '0;
        apply_reset();

        // Single host write at 0x100.
        cli_req = 3'b010;
        cli_we[1] = 1'b1;
        cli_addr[25 +: 25] = 25'h0000100;
        cli_wdata[32 +: 32] = 32'hCAFE0001;
        run_burst(3'b000, 1'b0, 8, win, lat);
        check_eq("t1_lat", 64'(lat), 64'd1);
        check_eq("t1_win", 64'(win), 64'd1);

        // Clients 1 and 2 continuously requesting alternate.
        apply_reset();
        new_req(1);
        new_req(2);
        for (int i = 0; i < 4; i++) begin
            run_burst(3'b110, 1'b0, 8, win, lat);
            check_eq("alt_win", 64'(win), 64'(alt_exp[i]));
        end

        // Client 0 read burst; stray pulse covered inside run_burst.
        apply_reset();
        new_req(0);
        cli_we[0] = 1'b0;
        run_burst(3'b000, 1'b0, 8, win, lat);
        check_eq("rd_win", 64'(win), 64'd0);

        // Urgent client 0 against continuous competition.
        apply_reset();
        cli0_urgent = 1'b1;
        new_req(0);
        new_req(1);
        new_req(2);
        seen1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_burst(3'b111, 1'b0, 8, win, lat);
            if (win == 1) seen1 = 1'b1;
`ifndef SDRAM_ARB_STARVE_EN
            check_eq("urgent_win", 64'(win), 64'd0);
`endif
        end
`ifdef SDRAM_ARB_STARVE_EN
        check_eq("starve_grant1", 64'(seen1), 64'd1);
`endif

        // Reset in the middle of a write burst, then clean restart.
        apply_reset();
        new_req(2);
        cli_we[2] = 1'b1;
        run_burst(3'b000, 1'b0, 3, win, lat);
        reset = 1'b1;
        tick();
        #1;
        check_quiet("mid_reset");
        reset = 1'b0;
        mem_wr_data_next = 1'b0;
        model_last = 2;
        new_req(2);
        cli_we[2] = 1'b1;
        run_burst(3'b000, 1'b0, 8, win, lat);
        check_eq("restart_lat", 64'(lat), 64'd1);
        check_eq("restart_win", 64'(win), 64'd2);

        // Randomized mixed read/write traffic.
        apply_reset();
        new_req(0);
        new_req(1);
        new_req(2);
        for (int i = 0; i < 30; i++) begin
            run_burst(3'b000, 1'b1, 8, win, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Three-client arbiter and sequencer in front of the single SDRAM controller port (mem_rd_req/mem_wr_req/mem_ack/mem_wr_data_next) of the SdramVgaFb design.
- Clients: 0 = VGA line-fetch reader (urgent when its FIFO runs low), 1 = serial-host pixel writer, 2 = fill/blit engine.
- Grants one burst at a time, muxes address/data and routes ack, write-data strobes and read-data-valid strobes back to the owning client.

Parameters:
BURST_LEN, 8, dwords per burst (write strobes or read valids counted before release)
NUM_CLI, 3, number of clients (fixed at 3 in this revision)
MAX_WAIT, 255, starvation limit in cycles (only with ARB_STARVE_EN)

Ports:
mem_clk  in  1  clock
reset  in  1  synchronous, active-high reset
cli_req  in  3  per-client request, held until matching cli_ack
cli_we  in  3  per-client 1=write burst, 0=read burst
cli_addr  in  75  3x25-bit burst start address, client n at [25n+24:25n]
cli_wdata  in  96  3x32-bit write data, client n at [32n+31:32n]
cli0_urgent  in  1  client 0 FIFO below low threshold
cli_ack  out  3  one-cycle pulse: request accepted by controller
cli_wr_next  out  3  routed mem_wr_data_next pulse: present next dword
cli_rd_valid  out  3  routed mem_rd_data_valid: read dword on shared bus
mem_rd_req  out  1  read request to controller
mem_wr_req  out  1  write request to controller
mem_addr  out  25  granted burst address
mem_wr_data  out  32  granted client write data (combinational mux on grant)
mem_ack  in  1  controller accepted request
mem_wr_data_next  in  1  controller consumed current write dword
mem_rd_data_valid  in  1  controller presenting a read dword

Behaviour:
- Reset (synchronous, active-high): state=IDLE, grant=0, last_grant=2, all outputs 0, burst counter 0. Reset mid-burst abandons the burst with no further pulses; the controller is reset by the same signal.
- FSM states: IDLE, ISSUE, WR_BURST, RD_BURST.
- IDLE, any cli_req set: choose winner, register grant, mem_addr<=cli_addr[grant], latch we, go ISSUE (1-cycle decision latency).
- Winner selection:
  - client 0 if cli_req[0] & cli0_urgent;
  - else round-robin over requesting clients starting at (last_grant+1) mod 3.
  - last_grant updates on every grant.
- ISSUE: mem_wr_req=we or mem_rd_req=~we, registered, asserted from the first ISSUE cycle until the cycle mem_ack is seen.
- On mem_ack: deassert the request next cycle; cli_ack[grant] pulses 1 cycle, the same cycle mem_ack is sampled. Go WR_BURST if we, else RD_BURST. The client may change addr/we after its ack.
- WR_BURST: cli_wr_next[grant]=mem_wr_data_next (combinational). Count pulses; on the BURST_LEN-th pulse go IDLE.
- RD_BURST: cli_rd_valid[grant]=mem_rd_data_valid; same counting rule.
- Burst counter: clog2(BURST_LEN)+1 bits, cleared on entry to ISSUE.
- Back-to-back: the IDLE decision may occur in the cycle after the last strobe; no zero-gap issue required.
- Strobes received in IDLE/ISSUE are ignored and not routed.
- mem_ack in IDLE is ignored.
- A client dropping cli_req before ack is a protocol violation; the issued request still completes.
- Never assert mem_rd_req and mem_wr_req together.
- Ungranted cli_ack/cli_wr_next/cli_rd_valid bits are always 0.

Optional Feature:
- Macro SDRAM_ARB_STARVE_EN.
- With the macro: per-client wait counters (8 bits, saturating at MAX_WAIT) increment while a client requests and is not granted, and clear on grant. A client at MAX_WAIT overrides urgency and round-robin; among several, the lowest index wins.
- Without the macro: no counters; urgent client 0 may starve clients 1 and 2 indefinitely.

Decomposition:
- Shared package sdram_arb_pkg: state encoding constants, client index constants (CLI_VGA=0, CLI_HOST=1, CLI_FILL=2), ADDR_W=25, DATA_W=32.
- One sub-module, rr_pick3: combinational round-robin/priority picker.
  - Inputs: req, urgent, last_grant, starve flags.
  - Outputs: valid and index.

Test Plan:
- Only client 1 requests write at addr 0x0000100 -> mem_wr_req high 1 cycle after req; on mem_ack, cli_ack[1] pulses; 8 mem_wr_data_next pulses routed to cli_wr_next[1]; return to IDLE.
- Clients 1 and 2 request continuously, last_grant=2 -> grants alternate 1,2,1,2 over 4 bursts.
- Client 0 urgent plus clients 1 and 2 requesting -> client 0 wins every decision; with SDRAM_ARB_STARVE_EN and MAX_WAIT=20, client 1 is granted once its wait count reaches 20.
- Client 0 read burst: 8 mem_rd_data_valid pulses appear only on cli_rd_valid[0]; a 9th stray pulse in IDLE is not routed.
- Reset asserted during WR_BURST after 3 strobes -> next cycle all outputs 0, state IDLE; a subsequent request restarts cleanly with the counter at 0.
- Interleaved read then write requests -> mem_rd_req and mem_wr_req never high in the same cycle (assertion checked every cycle).
